// File: rtl/prio_irq_ctrl.sv
// Nesting priority interrupt controller: edge/level capture, enable mask,
// single-outstanding req/ack to the CPU and in-service tracking retired by eoi.
module prio_irq_ctrl #(
    parameter int                   NUM_LINES  = 16,
    parameter int                   ID_WIDTH   = 4,
    parameter logic [NUM_LINES-1:0] EDGE_MODE  = '1,
    parameter logic [NUM_LINES-1:0] MASK_RESET = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_LINES-1:0] irq_lines,
    input  logic                 mask_we,
    input  logic [NUM_LINES-1:0] mask_wdata,
    output logic [NUM_LINES-1:0] mask,
    output logic                 irq_req,
    output logic [ID_WIDTH-1:0]  irq_id,
    input  logic                 irq_ack,
    input  logic                 eoi,
    input  logic [ID_WIDTH-1:0]  eoi_id,
    output logic                 active_valid,
    output logic [ID_WIDTH-1:0]  active_id
);

    typedef enum logic {IDLE, REQ} state_e;

    state_e                state_q, state_d;
    logic [NUM_LINES-1:0]  line_q;
    logic [NUM_LINES-1:0]  pending_q, pending_d;
    logic [NUM_LINES-1:0]  active_q, active_d;
    logic [NUM_LINES-1:0]  mask_q, mask_d;
    logic                  irq_req_q, irq_req_d;
    logic [ID_WIDTH-1:0]   irq_id_q, irq_id_d;

    logic [NUM_LINES-1:0]  capture;
    logic [NUM_LINES-1:0]  req_vec;
    logic                  cand_valid;
    logic [ID_WIDTH-1:0]   cand_id;
    logic                  eligible;
    logic                  ack_fire;

    assign capture  = (EDGE_MODE & irq_lines & ~line_q) | (~EDGE_MODE & irq_lines);
    assign req_vec  = pending_q & mask_q;
    assign ack_fire = (state_q == REQ) && irq_ack;
    assign mask_d   = mask_we ? mask_wdata : mask_q;

    // Highest-index search: later loop iterations overwrite earlier ones.
    always_comb begin
        cand_valid = 1'b0;
        cand_id    = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (req_vec[i]) begin
                cand_valid = 1'b1;
                cand_id    = ID_WIDTH'(i);
            end
        end
    end

    always_comb begin
        active_id = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (active_q[i]) active_id = ID_WIDTH'(i);
        end
    end

    assign active_valid = |active_q;
    assign eligible     = cand_valid && (!active_valid || (cand_id > active_id));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pending_d = pending_q;
        active_d  = active_q;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (ack_fire && (irq_id_q == ID_WIDTH'(i))) pending_d[i] = 1'b0;
            // eoi clear precedes ack set so a same-cycle pair leaves the id active;
            // ids with no matching line simply never decode.
            if (eoi && (eoi_id == ID_WIDTH'(i)))        active_d[i]  = 1'b0;
            if (ack_fire && (irq_id_q == ID_WIDTH'(i))) active_d[i]  = 1'b1;
        end
        pending_d = pending_d | capture;
    end

    always_comb begin
        state_d   = state_q;
        irq_req_d = irq_req_q;
        irq_id_d  = irq_id_q;
        case (state_q)
            IDLE: begin
                if (eligible) begin
                    state_d   = REQ;
                    irq_req_d = 1'b1;
                    irq_id_d  = cand_id;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_d   = IDLE;
                    irq_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                irq_req_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            line_q    <= '0;
            pending_q <= '0;
            active_q  <= '0;
            mask_q    <= MASK_RESET;
            irq_req_q <= 1'b0;
            irq_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            line_q    <= irq_lines;
            pending_q <= pending_d;
            active_q  <= active_d;
            mask_q    <= mask_d;
            irq_req_q <= irq_req_d;
            irq_id_q  <= irq_id_d;
        end
    end

    assign mask    = mask_q;
    assign irq_req = irq_req_q;
    assign irq_id  = irq_id_q;

endmodule

// File: tb/tb_prio_irq_ctrl.sv
// Directed bench for prio_irq_ctrl; line 4 is level-sensitive, all others edge.
module tb_prio_irq_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] irq_lines;
    logic        mask_we;
    logic [15:0] mask_wdata;
    logic [15:0] mask;
    logic        irq_req;
    logic [3:0]  irq_id;
    logic        irq_ack;
    logic        eoi;
    logic [3:0]  eoi_id;
    logic        active_valid;
    logic [3:0]  active_id;

    int total = 0;
    int bad   = 0;

    prio_irq_ctrl #(
        .NUM_LINES (16),
        .ID_WIDTH  (4),
        .EDGE_MODE (16'hFFEF),
        .MASK_RESET(16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_lines   (irq_lines),
        .mask_we     (mask_we),
        .mask_wdata  (mask_wdata),
        .mask        (mask),
        .irq_req     (irq_req),
        .irq_id      (irq_id),
        .irq_ack     (irq_ack),
        .eoi         (eoi),
        .eoi_id      (eoi_id),
        .active_valid(active_valid),
        .active_id   (active_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_mask(input logic [15:0] value);
        mask_we    = 1'b1;
        mask_wdata = value;
        tick();
        mask_we    = 1'b0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic pulse_eoi(input logic [3:0] id);
        eoi    = 1'b1;
        eoi_id = id;
        tick();
        eoi    = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        irq_lines  = '0;
        mask_we    = 1'b0;
        mask_wdata = '0;
        irq_ack    = 1'b0;
        eoi        = 1'b0;
        eoi_id     = '0;
        #1;
        check("rst_req", irq_req, 0);
        check("rst_id", irq_id, 0);
        check("rst_mask", mask, 16'h0000);
        check("rst_avalid", active_valid, 0);
        check("rst_aid", active_id, 0);
        tick();
        tick();
        rst_n = 1'b1;

        write_mask(16'hFFFF);
        check("mask_ffff", mask, 16'hFFFF);

        // Single edge pulse on line 3: two-edge latency, hold until ack.
        irq_lines[3] = 1'b1;
        tick();
        irq_lines[3] = 1'b0;
        check("l3_not_yet", irq_req, 0);
        tick();
        check("l3_req", irq_req, 1);
        check("l3_id", irq_id, 3);
        tick();
        tick();
        check("l3_hold_req", irq_req, 1);
        check("l3_hold_id", irq_id, 3);
        pulse_ack();
        check("l3_ack_req", irq_req, 0);
        check("l3_ack_avalid", active_valid, 1);
        check("l3_ack_aid", active_id, 3);
        pulse_eoi(4'd3);
        check("l3_eoi_avalid", active_valid, 0);
        tick();
        check("l3_idle", irq_req, 0);

        // Nesting: 5 in service, 9 preempts, 2 waits until both retire.
        irq_lines[5] = 1'b1;
        tick();
        irq_lines[5] = 1'b0;
        tick();
        check("l5_id", irq_id, 5);
        pulse_ack();
        check("l5_aid", active_id, 5);
        irq_lines[2] = 1'b1;
        irq_lines[9] = 1'b1;
        tick();
        irq_lines[2] = 1'b0;
        irq_lines[9] = 1'b0;
        tick();
        check("pre_req", irq_req, 1);
        check("pre_id", irq_id, 9);
        pulse_ack();
        check("pre_ack_aid", active_id, 9);
        check("pre_ack_req", irq_req, 0);
        tick();
        check("l2_blocked9", irq_req, 0);
        pulse_eoi(4'd9);
        check("eoi9_aid", active_id, 5);
        tick();
        check("l2_blocked5", irq_req, 0);
        pulse_eoi(4'd5);
        check("eoi5_avalid", active_valid, 0);
        check("eoi5_req_wait", irq_req, 0);
        tick();
        check("l2_req", irq_req, 1);
        check("l2_id", irq_id, 2);
        // eoi and ack for the same id on one edge: id ends up active.
        eoi     = 1'b1;
        eoi_id  = 4'd2;
        irq_ack = 1'b1;
        tick();
        eoi     = 1'b0;
        irq_ack = 1'b0;
        check("eoi_ack_avalid", active_valid, 1);
        check("eoi_ack_aid", active_id, 2);
        pulse_eoi(4'd2);
        check("eoi2_avalid", active_valid, 0);

        // Masked capture fires on unmask.
        write_mask(16'h0000);
        irq_lines[7] = 1'b1;
        tick();
        irq_lines[7] = 1'b0;
        tick();
        tick();
        check("masked_no_req", irq_req, 0);
        write_mask(16'h0080);
        check("unmask_mask", mask, 16'h0080);
        check("unmask_req_m", irq_req, 0);
        tick();
        check("unmask_req", irq_req, 1);
        check("unmask_id", irq_id, 7);
        pulse_ack();
        pulse_eoi(4'd7);
        write_mask(16'hFFFF);

        // Level line 4 held high re-requests after eoi.
        irq_lines[4] = 1'b1;
        tick();
        tick();
        check("lvl_req", irq_req, 1);
        check("lvl_id", irq_id, 4);
        pulse_ack();
        check("lvl_ack_req", irq_req, 0);
        check("lvl_ack_aid", active_id, 4);
        tick();
        tick();
        check("lvl_no_self_preempt", irq_req, 0);
        pulse_eoi(4'd4);
        check("lvl_eoi_avalid", active_valid, 0);
        tick();
        check("lvl_rereq", irq_req, 1);
        check("lvl_rereq_id", irq_id, 4);
        irq_lines[4] = 1'b0;
        pulse_ack();
        pulse_eoi(4'd4);
        tick();
        check("lvl_quiet", irq_req, 0);

        // Edge line 8 held high gives exactly one request.
        irq_lines[8] = 1'b1;
        tick();
        tick();
        check("edge_held_id", irq_id, 8);
        check("edge_held_req", irq_req, 1);
        pulse_ack();
        pulse_eoi(4'd8);
        tick();
        tick();
        check("edge_held_once", irq_req, 0);
        irq_lines[8] = 1'b0;

        // Frozen id: higher line and mask change while requesting 6.
        irq_lines[6] = 1'b1;
        tick();
        irq_lines[6] = 1'b0;
        tick();
        check("frz_id_start", irq_id, 6);
        irq_lines[12] = 1'b1;
        write_mask(16'hFFBF);
        irq_lines[12] = 1'b0;
        check("frz_req", irq_req, 1);
        check("frz_id", irq_id, 6);
        tick();
        check("frz_id_hold", irq_id, 6);
        pulse_ack();
        check("frz_ack_req", irq_req, 0);
        check("frz_ack_aid", active_id, 6);
        tick();
        check("l12_req", irq_req, 1);
        check("l12_id", irq_id, 12);

        // Asynchronous reset mid-request, checked before the next edge.
        rst_n = 1'b0;
        #2;
        check("arst_req", irq_req, 0);
        check("arst_avalid", active_valid, 0);
        check("arst_mask", mask, 16'h0000);
        check("arst_id", irq_id, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
